// File: rtl/axi4_stream_pkt_frag_pkg.sv
// Shared types and helpers for the byte-exact AXI4-Stream packet fragmenter.
package axi4_stream_pkt_frag_pkg;

  localparam int unsigned TDATA_WIDTH_DEF = 64;
  localparam int unsigned B               = TDATA_WIDTH_DEF / 8;
  localparam int unsigned BUF_CNT_W       = $clog2(2 * B + 1);
  localparam int unsigned KEEP_MAX        = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } frag_state_t;

  function automatic int unsigned count_keep(input logic [KEEP_MAX-1:0] keep);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if (keep[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Parametrised AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
  parameter int unsigned TDATA_WIDTH = 64,
  parameter int unsigned TID_WIDTH   = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TUSER_WIDTH = 1
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic                     tlast;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic                     tvalid;
  logic                     tready;

  modport master (output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
                  input  tready);
  modport slave  (input  tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
                  output tready);
endinterface

// File: rtl/axi4_stream_byte_buf.sv
// 2*NB byte realignment buffer: pop from the front, push behind what remains.
module axi4_stream_byte_buf #(
  parameter int unsigned NB   = 8,
  parameter int unsigned CNTW = $clog2(2 * NB + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [8*NB-1:0]     push_data_i,
  input  logic [CNTW-1:0]     push_cnt_i,
  input  logic [CNTW-1:0]     pop_cnt_i,
  output logic [16*NB-1:0]    data_o,
  output logic [CNTW-1:0]     count_o
);

  logic [16*NB-1:0] data_q, data_d, shifted, appended, mask;
  logic [CNTW-1:0]  count_q, count_d, kept;

  // Bytes above the count are forced to zero so output masking stays trivial.
  always_comb begin
    kept     = count_q - pop_cnt_i;
    shifted  = data_q >> (8 * pop_cnt_i);
    appended = shifted;
    count_d  = kept;
    if (push_i) begin
      appended = shifted | ({{(8*NB){1'b0}}, push_data_i} << (8 * kept));
      count_d  = kept + push_cnt_i;
    end
    mask   = ~({(16*NB){1'b1}} << (8 * count_d));
    data_d = appended & mask;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/axi4_stream_pkt_fragmenter.sv
// Byte-exact AXI4-Stream packet fragmenter with per-packet size sampling.
// Optional statistics counters enabled by defining AXI4_STREAM_PKT_FRAG_STAT_EN.
module axi4_stream_pkt_fragmenter
  import axi4_stream_pkt_frag_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH         = 64,
  parameter int unsigned TID_WIDTH           = 1,
  parameter int unsigned TDEST_WIDTH         = 1,
  parameter int unsigned TUSER_WIDTH         = 1,
  parameter int unsigned MAX_FRAG_SIZE       = 2048,
  parameter int unsigned MAX_FRAG_SIZE_WIDTH = $clog2(MAX_FRAG_SIZE + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [MAX_FRAG_SIZE_WIDTH-1:0] max_frag_size_i,
  axi4_stream_if.slave                   pkt_i,
  axi4_stream_if.master                  pkt_o
`ifdef AXI4_STREAM_PKT_FRAG_STAT_EN
  ,
  output logic [31:0]                    frag_cnt_o,
  output logic [31:0]                    pkt_cnt_o
`endif
);

  localparam int unsigned NB  = TDATA_WIDTH / 8;
  localparam int unsigned BCW = $clog2(2 * NB + 1);
  localparam int unsigned CW  = (MAX_FRAG_SIZE_WIDTH > BCW) ? MAX_FRAG_SIZE_WIDTH : BCW;
  localparam logic [CW-1:0] NB_C  = CW'(NB);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_FRAG_SIZE);

  frag_state_t            state_q, state_d;
  logic [CW-1:0]          frag_left_q, frag_left_d;
  logic [CW-1:0]          size_q, size_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;

  logic [16*NB-1:0]       buf_data;
  logic [BCW-1:0]         buf_cnt, rx_bytes, tx_bytes, pop_cnt;
  logic [CW-1:0]          cnt_c, tx_c, size_in, eff_size;
  logic                   rx_fire, tx_fire, out_valid, out_last, in_ready;
  logic [NB-1:0]          out_keep;
  logic [8*NB-1:0]        out_data;
  logic                   unused_strb;

  assign unused_strb = ^pkt_i.tstrb;

  assign size_in  = CW'(max_frag_size_i);
  assign eff_size = (size_in == '0 || size_in > MAX_C) ? MAX_C : size_in;
  assign cnt_c    = CW'(buf_cnt);

  always_comb begin
    tx_c = NB_C;
    if (cnt_c < tx_c)       tx_c = cnt_c;
    if (frag_left_q < tx_c) tx_c = frag_left_q;
  end

  assign tx_bytes  = BCW'(tx_c);
  assign rx_bytes  = BCW'(count_keep(KEEP_MAX'(pkt_i.tkeep)));
  assign in_ready  = (cnt_c <= NB_C) && (state_q != DRAIN);
  assign out_valid = (cnt_c != '0) &&
                     ((cnt_c >= NB_C) || (frag_left_q <= cnt_c) || (state_q == DRAIN));
  assign out_last  = out_valid &&
                     ((tx_c == frag_left_q) || ((state_q == DRAIN) && (tx_c == cnt_c)));
  assign rx_fire   = pkt_i.tvalid && in_ready;
  assign tx_fire   = out_valid && pkt_o.tready;
  assign pop_cnt   = tx_fire ? tx_bytes : '0;

  axi4_stream_byte_buf #(
    .NB   (NB),
    .CNTW (BCW)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (rx_fire),
    .push_data_i (pkt_i.tdata),
    .push_cnt_i  (rx_bytes),
    .pop_cnt_i   (pop_cnt),
    .data_o      (buf_data),
    .count_o     (buf_cnt)
  );

  always_comb begin
    out_keep = '0;
    out_data = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      out_keep[i] = out_valid && (CW'(i) < tx_c);
      if (out_keep[i]) out_data[8*i +: 8] = buf_data[8*i +: 8];
    end
  end

  // Size and sideband are captured only on the first beat so one packet is self-consistent.
  always_comb begin
    state_d     = state_q;
    frag_left_d = frag_left_q;
    size_d      = size_q;
    tid_d       = tid_q;
    tdest_d     = tdest_q;
    tuser_d     = tuser_q;
    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          state_d     = pkt_i.tlast ? DRAIN : RUN;
          size_d      = eff_size;
          frag_left_d = eff_size;
          tid_d       = pkt_i.tid;
          tdest_d     = pkt_i.tdest;
          tuser_d     = pkt_i.tuser;
        end
      end
      RUN, DRAIN: begin
        if (tx_fire) frag_left_d = out_last ? size_q : (frag_left_q - tx_c);
        if ((state_q == RUN) && rx_fire && pkt_i.tlast) state_d = DRAIN;
        if ((state_q == DRAIN) && tx_fire && (tx_c == cnt_c)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      frag_left_q <= '0;
      size_q      <= '0;
      tid_q       <= '0;
      tdest_q     <= '0;
      tuser_q     <= '0;
    end else begin
      state_q     <= state_d;
      frag_left_q <= frag_left_d;
      size_q      <= size_d;
      tid_q       <= tid_d;
      tdest_q     <= tdest_d;
      tuser_q     <= tuser_d;
    end
  end

`ifdef AXI4_STREAM_PKT_FRAG_STAT_EN
  logic [31:0] frag_cnt_q, pkt_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frag_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      if (tx_fire && out_last) frag_cnt_q <= frag_cnt_q + 32'd1;
      if ((state_q == DRAIN) && (state_d == IDLE)) pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign frag_cnt_o = frag_cnt_q;
  assign pkt_cnt_o  = pkt_cnt_q;
`endif

  assign pkt_i.tready = in_ready;
  assign pkt_o.tvalid = out_valid;
  assign pkt_o.tlast  = out_last;
  assign pkt_o.tkeep  = out_keep;
  assign pkt_o.tstrb  = out_keep;
  assign pkt_o.tdata  = out_data;
  assign pkt_o.tid    = tid_q;
  assign pkt_o.tdest  = tdest_q;
  assign pkt_o.tuser  = tuser_q;

endmodule

// File: tb/tb_axi4_stream_pkt_fragmenter.sv
// Scoreboard bench for axi4_stream_pkt_fragmenter (64-bit data, 2048-byte max fragment).
module tb_axi4_stream_pkt_fragmenter;

  logic        clk;
  logic        rst;
  logic [11:0] max_frag;
  int          total = 0;
  int          bad   = 0;
  int          rmode = 0;
  int          exp_frags = 0;
  int          exp_pkts  = 0;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [2:0]  sb;
  } beat_t;

  beat_t exp_q[$];

  axi4_stream_if #(.TDATA_WIDTH(64), .TID_WIDTH(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) in_if ();
  axi4_stream_if #(.TDATA_WIDTH(64), .TID_WIDTH(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) out_if ();

`ifdef AXI4_STREAM_PKT_FRAG_STAT_EN
  logic [31:0] frag_cnt, pkt_cnt;
`endif

  axi4_stream_pkt_fragmenter #(
    .TDATA_WIDTH   (64),
    .TID_WIDTH     (1),
    .TDEST_WIDTH   (1),
    .TUSER_WIDTH   (1),
    .MAX_FRAG_SIZE (2048)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .max_frag_size_i (max_frag),
    .pkt_i           (in_if),
    .pkt_o           (out_if)
`ifdef AXI4_STREAM_PKT_FRAG_STAT_EN
    ,
    .frag_cnt_o      (frag_cnt),
    .pkt_cnt_o       (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    out_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_if.tready = 1'b0;
        1:       out_if.tready = 1'b1;
        default: out_if.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every output handshake consumes one expected beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_if.tvalid && out_if.tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(out_if.tkeep), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", out_if.tdata, e.data);
          chk("tkeep", 64'(out_if.tkeep), 64'(e.keep));
          chk("tstrb", 64'(out_if.tstrb), 64'(e.keep));
          chk("tlast", 64'(out_if.tlast), 64'(e.last));
          chk("sideband", 64'({out_if.tuser, out_if.tdest, out_if.tid}), 64'(e.sb));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_pkt(input int len, input int sz, input int sz_after,
                          input logic [2:0] sb, input bit rnd, input bit chk_first);
    logic [7:0] pb [0:299];
    int eff, off, fl, n, nbeats, rem, idx;
    bit hs;
    beat_t e;
    for (int i = 0; i < len; i++) pb[i] = 8'($urandom);
    eff = (sz == 0 || sz > 2048) ? 2048 : sz;
    off = 0;
    while (off < len) begin
      fl = (len - off < eff) ? (len - off) : eff;
      while (fl > 0) begin
        n = (fl < 8) ? fl : 8;
        e.data = '0;
        for (int j = 0; j < n; j++) e.data[8*j +: 8] = pb[off + j];
        e.keep = 8'((1 << n) - 1);
        e.last = (fl == n);
        e.sb   = sb;
        exp_q.push_back(e);
        if (e.last) exp_frags++;
        off += n;
        fl  -= n;
      end
    end
    exp_pkts++;
    max_frag = 12'(sz);
    nbeats = (len + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      if (rnd) begin
        while ($urandom_range(0, 1) == 1) begin
          in_if.tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      rem = len - b * 8;
      for (int j = 0; j < 8; j++) begin
        idx = b * 8 + j;
        in_if.tdata[8*j +: 8] = (idx < len) ? pb[idx] : 8'hEE;
      end
      in_if.tkeep  = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      in_if.tstrb  = in_if.tkeep;
      in_if.tlast  = (b == nbeats - 1);
      in_if.tid    = sb[0];
      in_if.tdest  = sb[1];
      in_if.tuser  = sb[2];
      in_if.tvalid = 1'b1;
      hs = 1'b0;
      for (int c = 0; c < 2000 && !hs; c++) begin
        @(negedge clk);
        hs = in_if.tready;
        @(posedge clk);
        #1;
      end
      if (!hs) begin
        chk("input_handshake_timeout", 64'd0, 64'd1);
        in_if.tvalid = 1'b0;
        return;
      end
      if (b == 0) begin
        max_frag = 12'(sz_after);
        if (chk_first) begin
          in_if.tvalid = 1'b0;
          @(negedge clk);
          chk("latency_tvalid", 64'(out_if.tvalid), 64'd1);
          chk("tready_after_first", 64'(in_if.tready), 64'(nbeats > 1));
          @(posedge clk);
          #1;
        end
      end
    end
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 20000 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    max_frag     = 12'd16;
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tkeep  = '0;
    in_if.tstrb  = '0;
    in_if.tlast  = 1'b0;
    in_if.tid    = '0;
    in_if.tdest  = '0;
    in_if.tuser  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", 64'(out_if.tvalid), 64'd0);
    chk("rst_tlast", 64'(out_if.tlast), 64'd0);
    chk("rst_tkeep", 64'(out_if.tkeep), 64'd0);
    chk("rst_tdata", out_if.tdata, 64'd0);
    chk("rst_sideband", 64'({out_if.tuser, out_if.tdest, out_if.tid}), 64'd0);
    chk("rst_tready", 64'(in_if.tready), 64'd1);
`ifdef AXI4_STREAM_PKT_FRAG_STAT_EN
    chk("rst_frag_cnt", 64'(frag_cnt), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    rmode = 1;

    send_pkt(24, 16, 16, 3'b001, 1'b0, 1'b1);   // fragments 16 + 8
    drain("drain_size16");
    send_pkt(24, 12, 12, 3'b010, 1'b0, 1'b0);   // non-aligned: FF,0F,FF,0F
    drain("drain_size12");
    send_pkt(3, 5, 5, 3'b100, 1'b0, 1'b1);      // single short beat, DRAIN blocks input
    send_pkt(24, 16, 8, 3'b011, 1'b0, 1'b0);    // mid-packet size change ignored
    send_pkt(24, 8, 8, 3'b101, 1'b0, 1'b0);     // next packet picks up 8
    send_pkt(40, 0, 0, 3'b110, 1'b0, 1'b0);     // 0 means max size
    send_pkt(13, 1, 1, 3'b111, 1'b0, 1'b0);     // one-byte fragments
    send_pkt(17, 4000, 4000, 3'b000, 1'b0, 1'b0); // oversize clamps to max
    drain("drain_directed");

    rmode = 2;
    for (int p = 0; p < 200; p++) begin
      send_pkt($urandom_range(1, 300), $urandom_range(1, 64), $urandom_range(1, 64),
               3'($urandom), 1'b1, 1'b0);
    end
    drain("drain_random");
`ifdef AXI4_STREAM_PKT_FRAG_STAT_EN
    chk("frag_cnt", 64'(frag_cnt), 64'(exp_frags));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkts));
`endif

    // Reset in the middle of a stalled fragment, then a clean packet.
    rmode = 0;
    @(posedge clk);
    #1;
    max_frag     = 12'd64;
    in_if.tdata  = 64'h0706050403020100;
    in_if.tkeep  = 8'hFF;
    in_if.tstrb  = 8'hFF;
    in_if.tlast  = 1'b0;
    in_if.tvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_if.tvalid = 1'b0;
    @(negedge clk);
    chk("pre_reset_tvalid", 64'(out_if.tvalid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 64'(out_if.tvalid), 64'd0);
    chk("mid_rst_tready", 64'(in_if.tready), 64'd1);
    exp_frags = 0;
    exp_pkts  = 0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    rmode = 1;
    send_pkt(27, 10, 10, 3'b011, 1'b0, 1'b1);
    drain("drain_after_reset");
`ifdef AXI4_STREAM_PKT_FRAG_STAT_EN
    chk("frag_cnt_after_reset", 64'(frag_cnt), 64'(exp_frags));
    chk("pkt_cnt_after_reset", 64'(pkt_cnt), 64'(exp_pkts));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
